// File: rtl/px_pkg.sv
// Shared constants and control payload for the five-tap median filter.
package px_pkg;

  localparam int unsigned CH_W    = 8;
  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned PX_W    = CH_W * NUM_CH;
  localparam int unsigned TAPS    = 5;
  localparam int unsigned MED_LAT = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FILL_W  = 3;

  // Per-beat control travelling alongside the median datapath.
  typedef struct packed {
    logic valid;
    logic sol;
  } px_ctrl_t;

endpackage

// File: rtl/px_med5_ch.sv
// One colour channel: three-stage pipelined median-of-5 compare-exchange network.
module px_med5_ch #(
  parameter int unsigned W = px_pkg::CH_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [px_pkg::TAPS*W-1:0]  in_taps,
  output logic                       out_valid,
  output logic [W-1:0]               out_med
);

  import px_pkg::*;

  function automatic logic [W-1:0] min2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  logic [W-1:0] tap [TAPS];

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign tap[k] = in_taps[k*W +: W];
  end

  // Stage 1: order taps 0/1 and 2/3 as pairs; tap 4 passes through.
  logic         v1;
  logic [W-1:0] lo_a, hi_a, lo_b, hi_b, pass1;

  // Stage 2: the smaller pair-low and the larger pair-high each bound three
  // other values, so neither can be the median; keep the other three.
  logic         v2;
  logic [W-1:0] x_q, y_q, z_q;

  // Stage 1 registers: pair sort, only loaded on a valid beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1    <= 1'b0;
      lo_a  <= '0;
      hi_a  <= '0;
      lo_b  <= '0;
      hi_b  <= '0;
      pass1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        lo_a  <= min2(tap[0], tap[1]);
        hi_a  <= max2(tap[0], tap[1]);
        lo_b  <= min2(tap[2], tap[3]);
        hi_b  <= max2(tap[2], tap[3]);
        pass1 <= tap[4];
      end
    end
  end

  // Stage 2 registers: discard one value known low and one known high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v2  <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        x_q <= max2(lo_a, lo_b);
        y_q <= min2(hi_a, hi_b);
        z_q <= pass1;
      end
    end
  end

  // Stage 3 registers: median of the remaining three; holds while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_med   <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_med <= max2(min2(x_q, y_q), min2(max2(x_q, y_q), z_q));
      end
    end
  end

endmodule

// File: rtl/px_median5.sv
// Per-channel five-tap median filter with line-fill tracking and result counter.
module px_median5 #(
  parameter  int unsigned CH_W   = px_pkg::CH_W,
  parameter  int unsigned NUM_CH = px_pkg::NUM_CH,
  localparam int unsigned PXW    = CH_W * NUM_CH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_sol,
  input  logic [px_pkg::TAPS*PXW-1:0]   in_win,
  output logic                          out_valid,
  output logic [PXW-1:0]                out_px,
  output logic                          out_sol,
  output logic [px_pkg::CNT_W-1:0]      out_cnt
);

  import px_pkg::*;

  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt_c;
  logic              win_done_c;
  logic              sol_first_c;

  // Fill tracking: restart on start-of-line, otherwise count up and saturate.
  always_comb begin
    fill_nxt_c  = fill;
    win_done_c  = 1'b0;
    sol_first_c = 1'b0;
    if (in_valid) begin
      if (in_sol) begin
        fill_nxt_c = FILL_W'(1);
      end else if (fill != FILL_W'(TAPS)) begin
        fill_nxt_c = fill + FILL_W'(1);
      end
      win_done_c  = (fill_nxt_c == FILL_W'(TAPS));
      sol_first_c = !in_sol && (fill == FILL_W'(TAPS - 1));
    end
  end

  // Fill register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill <= '0;
    end else begin
      fill <= fill_nxt_c;
    end
  end

  // Control flags ride alongside the channel pipelines.
  px_ctrl_t ctrl_q [MED_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MED_LAT - 1; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      ctrl_q[0].valid <= win_done_c;
      ctrl_q[0].sol   <= sol_first_c;
      for (int unsigned i = 1; i < MED_LAT - 1; i++) begin
        ctrl_q[i] <= ctrl_q[i-1];
      end
    end
  end

  // Output flags and result counter update in the same cycle the median lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_sol <= 1'b0;
      out_cnt <= '0;
    end else if (ctrl_q[MED_LAT-2].valid) begin
      out_sol <= ctrl_q[MED_LAT-2].sol;
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  logic [NUM_CH-1:0] ch_valid;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [TAPS*CH_W-1:0] taps;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign taps[k*CH_W +: CH_W] = in_win[k*PXW + c*CH_W +: CH_W];
    end

    px_med5_ch #(
      .W (CH_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (win_done_c),
      .in_taps   (taps),
      .out_valid (ch_valid[c]),
      .out_med   (out_px[c*CH_W +: CH_W])
    );
  end

  // Channel valid flops are identical copies; the AND folds to one flop.
  assign out_valid = &ch_valid;

endmodule

// File: tb/tb_px_median5.sv
// Scoreboard bench for px_median5: sorted-median model, cycle-stamped expectations.
module tb_px_median5;

  import px_pkg::*;

  localparam int unsigned WIN_W = TAPS * PX_W;
  localparam int unsigned LAT   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sol = 1'b0;
  logic [WIN_W-1:0] in_win = '0;
  logic             out_valid;
  logic [PX_W-1:0]  out_px;
  logic             out_sol;
  logic [CNT_W-1:0] out_cnt;

  always #5 clk = ~clk;

  px_median5 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .in_win    (in_win),
    .out_valid (out_valid),
    .out_px    (out_px),
    .out_sol   (out_sol),
    .out_cnt   (out_cnt)
  );

  typedef struct {
    int              due;
    logic [PX_W-1:0] px;
    logic            sol;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  logic             rst_at_edge = 1'b0;
  int               errors = 0;
  int               checks = 0;
  int               mfill = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [PX_W-1:0]  last_px = '0;
  logic             last_sol = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CH_W-1:0] med5(input logic [WIN_W-1:0] w, input int c);
    logic [CH_W-1:0] v [TAPS];
    logic [CH_W-1:0] t;
    for (int k = 0; k < TAPS; k++) v[k] = w[k*PX_W + c*CH_W +: CH_W];
    for (int i = 1; i < TAPS; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[j] < v[j-1]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      end
    end
    return v[2];
  endfunction

  function automatic logic [PX_W-1:0] model_px(input logic [WIN_W-1:0] w);
    logic [PX_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*CH_W +: CH_W] = med5(w, c);
    return r;
  endfunction

  function automatic logic [WIN_W-1:0] rnd_win();
    logic [WIN_W-1:0] w;
    w = '0;
    for (int k = 0; k < TAPS * NUM_CH; k++) w[k*CH_W +: CH_W] = CH_W'($urandom);
    return w;
  endfunction

  // Channel 2 = R, 1 = G, 0 = B; each argument packs tap k at [k*CH_W +: CH_W].
  function automatic logic [WIN_W-1:0] mk_win(input logic [TAPS*CH_W-1:0] r,
                                              input logic [TAPS*CH_W-1:0] g,
                                              input logic [TAPS*CH_W-1:0] b);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int k = 0; k < TAPS; k++) begin
      w[k*PX_W + 2*CH_W +: CH_W] = r[k*CH_W +: CH_W];
      w[k*PX_W + 1*CH_W +: CH_W] = g[k*CH_W +: CH_W];
      w[k*PX_W + 0*CH_W +: CH_W] = b[k*CH_W +: CH_W];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_at_edge = rst;
  end

  // Monitor: compares outputs against the scoreboard each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_px", 32'(out_px), 32'd0);
      chk("rst_sol", 32'(out_sol), 32'd0);
      chk("rst_cnt", 32'(out_cnt), 32'd0);
      last_px = '0;
      last_sol = 1'b0;
      exp_cnt = '0;
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk("missed_result", 32'(cyc), 32'(e.due));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'd1;
        chk("valid", 32'(out_valid), 32'd1);
        chk("px", 32'(out_px), 32'(e.px));
        chk("sol", 32'(out_sol), 32'(e.sol));
        chk("cnt", 32'(out_cnt), 32'(exp_cnt));
        last_px = e.px;
        last_sol = e.sol;
      end else begin
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("hold_px", 32'(out_px), 32'(last_px));
        chk("hold_sol", 32'(out_sol), 32'(last_sol));
        chk("hold_cnt", 32'(out_cnt), 32'(exp_cnt));
      end
    end
  end

  task automatic beat(input logic v, input logic s, input logic [WIN_W-1:0] w);
    int   old;
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = v;
    in_sol = s;
    in_win = w;
    if (v) begin
      old = mfill;
      if (s) mfill = 1;
      else if (mfill < TAPS) mfill = mfill + 1;
      if (mfill == TAPS) begin
        e.due = cyc + LAT;
        e.px  = model_px(w);
        e.sol = !s && (old == TAPS - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, '0);
  endtask

  // Reset with junk beats presented; results not yet on the output are dropped.
  task automatic rst_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b1;
      in_sol = 1'($urandom_range(0, 1));
      in_win = rnd_win();
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) sb.delete(sb.size() - 1);
      mfill = 0;
    end
  endtask

  task automatic line(input int n, input bit gaps);
    beat(1'b1, 1'b1, rnd_win());
    for (int i = 1; i < n; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) beat(1'b0, 1'b0, rnd_win());
      beat(1'b1, 1'b0, rnd_win());
    end
  endtask

  initial begin
    logic [WIN_W-1:0] w;

    rst_cycles(3);

    // Basic line: taps 10,50,30,20,40 on every channel.
    w = mk_win({8'd40, 8'd20, 8'd30, 8'd50, 8'd10},
               {8'd40, 8'd20, 8'd30, 8'd50, 8'd10},
               {8'd40, 8'd20, 8'd30, 8'd50, 8'd10});
    beat(1'b1, 1'b1, w);
    repeat (4) beat(1'b1, 1'b0, w);
    idle(6);

    // Full-throughput line of 20 beats.
    line(20, 1'b0);
    idle(5);

    // Channel-distinct taps: R 255,0,128,1,254  G all 3  B 9,7,7,9,8.
    w = mk_win({8'd254, 8'd1, 8'd128, 8'd0, 8'd255},
               {8'd3, 8'd3, 8'd3, 8'd3, 8'd3},
               {8'd8, 8'd9, 8'd7, 8'd7, 8'd9});
    beat(1'b1, 1'b1, w);
    repeat (4) beat(1'b1, 1'b0, w);
    idle(4);

    // Duplicate values: 7,7,7,3,9.
    w = mk_win({8'd9, 8'd3, 8'd7, 8'd7, 8'd7},
               {8'd9, 8'd3, 8'd7, 8'd7, 8'd7},
               {8'd9, 8'd3, 8'd7, 8'd7, 8'd7});
    beat(1'b1, 1'b1, w);
    repeat (4) beat(1'b1, 1'b0, w);
    idle(4);

    // New line starts at beat 7 while beats 5 and 6 are in flight.
    beat(1'b1, 1'b1, rnd_win());
    repeat (5) beat(1'b1, 1'b0, rnd_win());
    beat(1'b1, 1'b1, rnd_win());
    repeat (6) beat(1'b1, 1'b0, rnd_win());
    idle(5);

    // Line with random gaps, then back-to-back lines.
    line(15, 1'b1);
    line(6, 1'b0);
    line(7, 1'b1);
    idle(5);

    // Reset right behind window-complete beats.
    beat(1'b1, 1'b1, rnd_win());
    repeat (5) beat(1'b1, 1'b0, rnd_win());
    rst_cycles(2);
    idle(3);
    beat(1'b1, 1'b1, rnd_win());
    repeat (4) beat(1'b1, 1'b0, rnd_win());
    idle(5);

    // Counter wrap: 65536 results from a clean reset.
    rst_cycles(1);
    line(65540, 1'b0);
    idle(6);

    chk("drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got=cycle %0d exp=finish before limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
